// File: rtl/ej32_obuf_if.sv
// ej32_obuf_if: byte-bus read port and byte-stream output of the OBUF reader
interface ej32_obuf_if #(parameter int ASZ = 17);
    logic           mem_req;
    logic [ASZ-1:0] mem_a;
    logic           mem_gnt;
    logic [7:0]     mem_d;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    modport master(output mem_req, mem_a, tx_valid, tx_data, input mem_gnt, mem_d, tx_ready);
    modport slave(input mem_req, mem_a, tx_valid, tx_data, output mem_gnt, mem_d, tx_ready);
endinterface

// File: rtl/ej32_obuf_reader.sv
// ej32_obuf_reader: drains the OBUF ring over the byte bus into a small FIFO feeding a valid/ready byte stream
module ej32_obuf_reader #(
    parameter int OBUF    = 'h1400,
    parameter int OBUF_SZ = 'h200,
    parameter int ASZ     = 17,
    parameter int DEPTH   = 4,
    localparam int OW     = $clog2(OBUF_SZ),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic [OW-1:0] wr_ofs,
    output logic [OW-1:0] rd_ofs,
    output logic          empty,
    output logic [1:0]    state,
    ej32_obuf_if.master   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
    localparam logic [ASZ-1:0] BASE = ASZ'(OBUF);
    localparam logic [PW+1:0]  DEP  = (PW+2)'(DEPTH);
    state_t        st, st_n;
    logic [OW-1:0] rd_n;
    logic [PW:0]   wp, rp, cnt, cnt_n;
    logic          inflight, acc, push, pop, credit_ok, more;
    logic [7:0]    fifo [DEPTH];
    assign cnt = wp - rp;
    assign credit_ok = ({1'b0, cnt} + (PW+2)'(inflight)) < DEP;
    assign bus.mem_req = en && !flush && rd_ofs != wr_ofs && credit_ok && rst_n;
    assign bus.mem_a = BASE + ASZ'(rd_ofs);
    assign acc = bus.mem_req && bus.mem_gnt;
    assign push = inflight && !flush;
    assign pop = bus.tx_valid && bus.tx_ready && !flush;
    assign bus.tx_valid = cnt != '0;
    assign bus.tx_data = bus.tx_valid ? fifo[rp[PW-1:0]] : 8'h00;
    assign empty = rd_ofs == wr_ofs && cnt == '0 && !inflight;
    assign state = st;
    // trace state reflects the registers as they will be after this edge
    always_comb begin
        rd_n = acc ? rd_ofs + OW'(1) : rd_ofs;
        cnt_n = cnt + (PW+1)'(push) - (PW+1)'(pop);
        more = en && rd_n != wr_ofs;
        st_n = !more ? (acc ? DRAIN : IDLE) :
               (({1'b0, cnt_n} + (PW+2)'(acc)) < DEP ? FETCH : HOLD);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ofs <= '0;
            inflight <= 1'b0;
            wp <= '0;
            rp <= '0;
            st <= IDLE;
        end else if (flush) begin
            rd_ofs <= wr_ofs;
            inflight <= 1'b0;
            wp <= '0;
            rp <= '0;
            st <= IDLE;
        end else begin
            rd_ofs <= rd_n;
            inflight <= acc;
            if (push) wp <= wp + (PW+1)'(1);
            if (pop) rp <= rp + (PW+1)'(1);
            st <= st_n;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wp[PW-1:0]] <= bus.mem_d;
    end
endmodule

// File: tb/tb_ej32_obuf_reader.sv
// tb_ej32_obuf_reader: randomized bus/consumer stimulus checked against a byte-stream scoreboard of the OBUF ring
module tb_ej32_obuf_reader;
    localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       flush = 1'b0;
    logic [8:0] wr_ofs = '0;
    logic [8:0] rd_ofs;
    logic       empty;
    logic [1:0] state;
    logic [7:0] ram [512];
    logic [7:0] sb [$];
    logic [16:0] acc_q [$];
    int         pop_q [$];
    int         n_vec = 0, n_bad = 0, cyc = 0, acc_cnt = 0;
    logic [8:0] mrd = '0;
    logic       pw = 1'b0;
    logic [16:0] pa = '0;
    ej32_obuf_if #(.ASZ(17)) bus();
    ej32_obuf_reader #(.OBUF('h1400), .OBUF_SZ('h200), .ASZ(17), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .wr_ofs(wr_ofs),
        .rd_ofs(rd_ofs), .empty(empty), .state(state), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // memory answers one cycle after acceptance, garbage otherwise
    always @(posedge clk)
        bus.mem_d <= (bus.mem_req && bus.mem_gnt) ? ram[9'(bus.mem_a - 17'h1400)] : 8'($urandom);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask
    task automatic set_wr(input logic [8:0] n);
        for (logic [8:0] o = wr_ofs; o != n; o++) sb.push_back(ram[o]);
        wr_ofs = n;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input int bound);
        logic done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            done = sb.size() == 0 && !bus.tx_valid && empty;
        end
        chk("drain", 32'(done), 32'd1);
    endtask
    always @(negedge clk) begin
        logic [31:0] w;
        if (!rst_n) begin
            sb.delete();
            mrd = '0;
            pw = 1'b0;
        end else if (flush) begin
            sb.delete();
            mrd = wr_ofs;
            pw = 1'b0;
        end else begin
            if (pw && bus.mem_req) chk("a_stable", 32'(bus.mem_a), 32'(pa));
            pw = bus.mem_req && !bus.mem_gnt;
            pa = bus.mem_a;
            if (bus.mem_req && bus.mem_gnt) begin
                chk("mem_a", 32'(bus.mem_a), 32'(17'h1400 + 17'(mrd)));
                mrd++;
                acc_cnt++;
                acc_q.push_back(bus.mem_a);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (sb.size() != 0) w = 32'(sb.pop_front());
                else w = 32'hdead_beef;
                chk("tx_data", 32'(bus.tx_data), w);
                pop_q.push_back(cyc);
            end
        end
    end
    initial begin
        int a0, p0, added, k;
        logic [16:0] wa [4];
        wa = '{17'h15FE, 17'h15FF, 17'h1400, 17'h1401};
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h41;
        ram[1] = 8'h42;
        ram[2] = 8'h43;
        bus.mem_gnt = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        tick();
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_a", 32'(bus.mem_a), 32'h1400);
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd", 32'(rd_ofs), 32'd0);
        rst_n = 1'b1;
        tick();
        set_wr(9'd3);
        @(negedge clk);
        chk("t1_req", 32'(bus.mem_req), 32'd1);
        chk("t1_v0", 32'(bus.tx_valid), 32'd0);
        @(negedge clk);
        chk("t1_v1", 32'(bus.tx_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_stream", 32'(bus.tx_valid), 32'd1);
        end
        @(negedge clk);
        chk("t1_done", 32'(bus.tx_valid), 32'd0);
        chk("t1_rd", 32'(rd_ofs), 32'd3);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_state", 32'(state), 32'(S_IDLE));
        tick();
        bus.tx_ready = 1'b0;
        a0 = acc_cnt;
        set_wr(9'd11);
        repeat (10) tick();
        chk("t2_acc", 32'(acc_cnt - a0), 32'd4);
        chk("t2_req", 32'(bus.mem_req), 32'd0);
        chk("t2_state", 32'(state), 32'(S_HOLD));
        p0 = pop_q.size();
        bus.tx_ready = 1'b1;
        wait_done(50);
        chk("t2_count", 32'(pop_q.size() - p0), 32'd8);
        if (pop_q.size() - p0 >= 8) chk("t2_gap", 32'(pop_q[p0+7] - pop_q[p0]), 32'd7);
        tick();
        wr_ofs = 9'h1FE;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        acc_q.delete();
        set_wr(9'h002);
        wait_done(50);
        chk("wrap_n", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("wrap_a", 32'(acc_q[i]), 32'(wa[i]));
        chk("wrap_rd", 32'(rd_ofs), 32'h002);
        p0 = pop_q.size();
        added = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            bus.mem_gnt = 1'($urandom_range(0, 1));
            bus.tx_ready = $urandom_range(0, 3) != 0;
            en = $urandom_range(0, 7) != 0;
            if (added < 64 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(1, 4);
                if (k > 64 - added) k = 64 - added;
                set_wr(wr_ofs + 9'(k));
                added += k;
            end
        end
        en = 1'b1;
        bus.mem_gnt = 1'b1;
        bus.tx_ready = 1'b1;
        wait_done(200);
        chk("rand_count", 32'(pop_q.size() - p0), 32'(added));
        tick();
        bus.tx_ready = 1'b0;
        a0 = acc_cnt;
        set_wr(wr_ofs + 9'd8);
        for (int i = 0; i < 20 && acc_cnt - a0 < 4; i++) tick();
        chk("fl_fill", 32'(acc_cnt - a0), 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(bus.tx_valid), 32'd0);
        chk("fl_rd", 32'(rd_ofs), 32'(wr_ofs));
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_req", 32'(bus.mem_req), 32'd0);
        p0 = pop_q.size();
        bus.tx_ready = 1'b1;
        repeat (8) tick();
        chk("fl_ghost", 32'(pop_q.size() - p0), 32'd0);
        set_wr(wr_ofs + 9'd20);
        repeat (6) tick();
        rst_n = 1'b0;
        wr_ofs = '0;
        tick();
        chk("mr_req", 32'(bus.mem_req), 32'd0);
        chk("mr_a", 32'(bus.mem_a), 32'h1400);
        chk("mr_valid", 32'(bus.tx_valid), 32'd0);
        chk("mr_data", 32'(bus.tx_data), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_rd", 32'(rd_ofs), 32'd0);
        rst_n = 1'b1;
        p0 = pop_q.size();
        acc_q.delete();
        set_wr(9'd2);
        wait_done(50);
        chk("mr_count", 32'(pop_q.size() - p0), 32'd2);
        chk("mr_n", 32'(acc_q.size()), 32'd2);
        for (int i = 0; i < 2 && i < acc_q.size(); i++) chk("mr_a", 32'(acc_q[i]), 32'h1400 + 32'(i));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
